// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared opcodes, enums and control bundle for the RV32I control pipe
package control_pkg;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_PASSB = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } alu_mode_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_B = 3'd1,
        IMM_U = 3'd2,
        IMM_J = 3'd3,
        IMM_S = 3'd4
    } imm_fmt_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_src_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        result_src_t result_src;
        alu_mode_t   alu_mode;
        logic        alu_src_a;
        logic        alu_src_b;
        imm_fmt_t    imm_format;
        logic        branch;
        logic [2:0]  branch_cond;
        logic        jump;
        logic        jalr;
        logic [2:0]  mem_size;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } ctrl_bundle_t;

    // alt selects SUB/SRA; callers pass 0 where instr[30] has no meaning.
    function automatic alu_mode_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational RV32I instruction decoder
module control_decode
    import control_pkg::*;
(
    input  logic [31:0]  instr,
    output ctrl_bundle_t ctrl,
    output logic         illegal,
    output logic         uses_rs1,
    output logic         uses_rs2
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       funct7_ok;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign funct7_ok = (funct7 == 7'h00) || (funct7 == 7'h20);

    always_comb begin
        ctrl     = '0;
        illegal  = 1'b0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        ctrl.rd  = instr[11:7];
        ctrl.rs1 = instr[19:15];
        ctrl.rs2 = instr[24:20];

        case (opcode)
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.alu_src_b  = 1'b1;
                ctrl.imm_format = IMM_I;
                ctrl.mem_size   = funct3;
                illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OP_IMM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.imm_format = IMM_I;
                // Only the shift-immediates carry a meaningful funct7.
                if (funct3 == 3'd1 || funct3 == 3'd5) begin
                    ctrl.alu_mode = alu_from_funct3(funct3, instr[30]);
                    illegal       = !funct7_ok;
                end else begin
                    ctrl.alu_mode = alu_from_funct3(funct3, 1'b0);
                end
            end
            OP_AUIPC: begin
                uses_rs1        = 1'b0;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.imm_format = IMM_U;
            end
            OP_STORE: begin
                uses_rs2        = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.imm_format = IMM_S;
                ctrl.mem_size   = funct3;
                illegal = (funct3 > 3'd2);
            end
            OP_REG: begin
                uses_rs2       = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_mode  = alu_from_funct3(funct3, instr[30]);
                illegal        = !funct7_ok;
            end
            OP_LUI: begin
                uses_rs1        = 1'b0;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_mode   = ALU_PASSB;
                ctrl.alu_src_b  = 1'b1;
                ctrl.imm_format = IMM_U;
            end
            OP_BRANCH: begin
                uses_rs2         = 1'b1;
                ctrl.branch      = 1'b1;
                ctrl.branch_cond = funct3;
                ctrl.imm_format  = IMM_B;
                case (funct3[2:1])
                    2'b00:   ctrl.alu_mode = ALU_SUB;
                    2'b10:   ctrl.alu_mode = ALU_SLT;
                    2'b11:   ctrl.alu_mode = ALU_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jalr       = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.alu_src_b  = 1'b1;
                ctrl.imm_format = IMM_I;
            end
            OP_JAL: begin
                uses_rs1        = 1'b0;
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.imm_format = IMM_J;
            end
            default: begin
                uses_rs1 = 1'b0;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_pipe.sv
// rtl/control_pipe.sv - ID/EX control register with load-use hazard, bubbles and event counters
module control_pipe
    import control_pkg::*;
#(
    parameter int ALU_MODE_W = 4,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16,
    parameter bit HAZARD_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           id_instr,
    input  logic                  id_valid,
    input  logic                  flush,
    output logic                  stall_if,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_write,
    output logic [1:0]            ex_result_src,
    output logic [ALU_MODE_W-1:0] ex_alu_mode,
    output logic                  ex_alu_src_a,
    output logic                  ex_alu_src_b,
    output logic [2:0]            ex_imm_format,
    output logic                  ex_branch,
    output logic [2:0]            ex_branch_cond,
    output logic                  ex_jump,
    output logic                  ex_jalr,
    output logic [2:0]            ex_mem_size,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic                  illegal_instr,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam ctrl_bundle_t BUBBLE = '0;

    ctrl_bundle_t dec_ctrl;
    logic         dec_illegal;
    logic         dec_uses_rs1;
    logic         dec_uses_rs2;
    ctrl_bundle_t ex_q;
    logic         ex_valid_q;
    logic         illegal_q;
    logic         hazard;

    control_decode u_decode (
        .instr    (id_instr),
        .ctrl     (dec_ctrl),
        .illegal  (dec_illegal),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2)
    );

    // A load in EX whose destination feeds the ID instruction must wait one cycle.
    assign hazard = HAZARD_EN && id_valid && ex_valid_q
                 && (ex_q.result_src == RES_MEM) && (ex_q.rd != 5'd0)
                 && ((dec_uses_rs1 && (dec_ctrl.rs1 == ex_q.rd))
                  || (dec_uses_rs2 && (dec_ctrl.rs2 == ex_q.rd)));

    assign stall_if = hazard && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= BUBBLE;
            ex_valid_q  <= 1'b0;
            illegal_q   <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (flush) begin
            ex_q       <= BUBBLE;
            ex_valid_q <= 1'b0;
            if (flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
        end else if (hazard) begin
            ex_q       <= BUBBLE;
            ex_valid_q <= 1'b0;
            if (stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
        end else if (id_valid && dec_illegal) begin
            ex_q       <= BUBBLE;
            ex_valid_q <= 1'b0;
            illegal_q  <= 1'b1;
        end else if (id_valid) begin
            ex_q       <= dec_ctrl;
            ex_valid_q <= 1'b1;
        end else begin
            ex_q       <= BUBBLE;
            ex_valid_q <= 1'b0;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_mem_write   = ex_q.mem_write;
    assign ex_result_src  = ex_q.result_src;
    assign ex_alu_mode    = ALU_MODE_W'(ex_q.alu_mode);
    assign ex_alu_src_a   = ex_q.alu_src_a;
    assign ex_alu_src_b   = ex_q.alu_src_b;
    assign ex_imm_format  = ex_q.imm_format;
    assign ex_branch      = ex_q.branch;
    assign ex_branch_cond = ex_q.branch_cond;
    assign ex_jump        = ex_q.jump;
    assign ex_jalr        = ex_q.jalr;
    assign ex_mem_size    = ex_q.mem_size;
    assign ex_rd          = REG_ADDR_W'(ex_q.rd);
    assign ex_rs1         = REG_ADDR_W'(ex_q.rs1);
    assign ex_rs2         = REG_ADDR_W'(ex_q.rs2);
    assign illegal_instr  = illegal_q;

endmodule

// File: tb/tb_control_pipe.sv
// tb/tb_control_pipe.sv - directed self-checking bench for control_pipe
module tb_control_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        flush;
    logic        stall_if;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_write;
    logic [1:0]  ex_result_src;
    logic [3:0]  ex_alu_mode;
    logic        ex_alu_src_a;
    logic        ex_alu_src_b;
    logic [2:0]  ex_imm_format;
    logic        ex_branch;
    logic [2:0]  ex_branch_cond;
    logic        ex_jump;
    logic        ex_jalr;
    logic [2:0]  ex_mem_size;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic        illegal_instr;
    logic [1:0]  stall_count;
    logic [1:0]  flush_count;

    int n_checks = 0;
    int n_pass   = 0;

    control_pipe #(
        .ALU_MODE_W (4),
        .REG_ADDR_W (5),
        .CNT_W      (2),
        .HAZARD_EN  (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_instr       (id_instr),
        .id_valid       (id_valid),
        .flush          (flush),
        .stall_if       (stall_if),
        .ex_valid       (ex_valid),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_write   (ex_mem_write),
        .ex_result_src  (ex_result_src),
        .ex_alu_mode    (ex_alu_mode),
        .ex_alu_src_a   (ex_alu_src_a),
        .ex_alu_src_b   (ex_alu_src_b),
        .ex_imm_format  (ex_imm_format),
        .ex_branch      (ex_branch),
        .ex_branch_cond (ex_branch_cond),
        .ex_jump        (ex_jump),
        .ex_jalr        (ex_jalr),
        .ex_mem_size    (ex_mem_size),
        .ex_rd          (ex_rd),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .illegal_instr  (illegal_instr),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr);
        id_instr = instr;
        id_valid = 1'b1;
        step();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, ex_valid, 0);
        check({tag, "_regw"}, ex_reg_write, 0);
        check({tag, "_illegal"}, illegal_instr, 0);
        check({tag, "_stall_cnt"}, stall_count, 0);
        check({tag, "_flush_cnt"}, flush_count, 0);
    endtask

    initial begin
        rst = 1'b1; id_instr = 32'h0; id_valid = 1'b0; flush = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_reset("rst0");

        // addi x5,x6,10
        issue(32'h00A30293);
        check("addi_valid", ex_valid, 1);
        check("addi_regw", ex_reg_write, 1);
        check("addi_alu", ex_alu_mode, 0);
        check("addi_srcb", ex_alu_src_b, 1);
        check("addi_imm", ex_imm_format, 0);
        check("addi_rd", ex_rd, 5);
        check("addi_rs1", ex_rs1, 6);

        // lw x5,0(x6)
        issue(32'h00032283);
        check("lw_res", ex_result_src, 1);
        check("lw_size", ex_mem_size, 2);
        check("lw_srcb", ex_alu_src_b, 1);
        // add x7,x5,x1 depends on the load through rs1
        id_instr = 32'h001283B3;
        #1;
        check("lu_stall_if", stall_if, 1);
        step();
        check("lu_bubble", ex_valid, 0);
        check("lu_bubble_regw", ex_reg_write, 0);
        check("lu_stall_cnt", stall_count, 1);
        check("lu_release", stall_if, 0);
        step();
        check("lu_add_valid", ex_valid, 1);
        check("lu_add_rd", ex_rd, 7);
        check("lu_add_rs2", ex_rs2, 1);

        // lw x0 then add x7,x0,x1: no stall on x0
        issue(32'h00032003);
        id_instr = 32'h001003B3;
        #1;
        check("x0_no_stall", stall_if, 0);
        step();
        check("x0_valid", ex_valid, 1);
        check("x0_stall_cnt", stall_count, 1);

        // lw x5 then lui whose rs1 field is 5: lui does not read rs1
        issue(32'h00032283);
        id_instr = 32'h000280B7;
        #1;
        check("lui_no_stall", stall_if, 0);
        step();
        check("lui_alu", ex_alu_mode, 7);
        check("lui_imm", ex_imm_format, 2);

        // lw x5 then sub x7,x1,x5 (rs2 hazard) with a simultaneous flush
        issue(32'h00032283);
        id_instr = 32'h405083B3;
        #1;
        check("rs2_stall_if", stall_if, 1);
        flush = 1'b1;
        #1;
        check("flush_beats_stall", stall_if, 0);
        step();
        flush = 1'b0;
        check("flush_bubble", ex_valid, 0);
        check("flush_cnt1", flush_count, 1);
        check("flush_stall_cnt", stall_count, 1);
        step();
        check("sub_alu", ex_alu_mode, 1);

        // bltu x1,x2
        issue(32'h0020E063);
        check("bltu_branch", ex_branch, 1);
        check("bltu_cond", ex_branch_cond, 6);
        check("bltu_alu", ex_alu_mode, 10);
        check("bltu_imm", ex_imm_format, 1);
        check("bltu_regw", ex_reg_write, 0);

        // sw x2,4(x1)
        issue(32'h0020A223);
        check("sw_memw", ex_mem_write, 1);
        check("sw_imm", ex_imm_format, 4);
        check("sw_alu", ex_alu_mode, 0);
        check("sw_regw", ex_reg_write, 0);

        // jal x1
        issue(32'h000000EF);
        check("jal_jump", ex_jump, 1);
        check("jal_res", ex_result_src, 2);
        check("jal_srca", ex_alu_src_a, 1);
        check("jal_imm", ex_imm_format, 3);

        // srai x5,x6,3
        issue(32'h40335293);
        check("srai_alu", ex_alu_mode, 8);

        // Illegal opcode, then sticky flag across legal traffic
        issue(32'h0000007F);
        check("ill_bubble", ex_valid, 0);
        check("ill_flag", illegal_instr, 1);
        issue(32'h00A30293);
        check("ill_then_addi", ex_valid, 1);
        check("ill_sticky", illegal_instr, 1);
        issue(32'h00002063);
        check("ill_branch_f3", ex_valid, 0);
        issue(32'h021283B3);
        check("ill_funct7", ex_valid, 0);

        id_valid = 1'b0;
        step();
        check("idle_bubble", ex_valid, 0);

        // Reset after traffic
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset("rst1");

        // Saturation: five consecutive flushes on a 2-bit counter
        id_instr = 32'h00A30293;
        id_valid = 1'b1;
        flush    = 1'b1;
        step();
        step();
        check("sat_cnt2", flush_count, 2);
        step();
        step();
        step();
        flush = 1'b0;
        check("sat_cnt5", flush_count, 3);
        check("sat_bubble", ex_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
